// File: rtl/multicycle_control_if.sv
// Shared memory-port handshake between the multi-cycle controller and memory.
// The controller drives the request side (master); memory answers with ready (slave).
interface multicycle_control_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: FETCH -> DECODE -> EXECUTE -> [MEM] -> [WRITEBACK].
// Handles the shared memory request/ready handshake, counts retired
// instructions and latches a sticky trap on illegal opcodes.
// Optional build macro: CTRL_MEM_TIMEOUT_EN adds a memory-wait watchdog that
// traps (cause 2'b10) after MEM_TIMEOUT cycles without mem_ready.
module multicycle_control #(
  parameter int ALU_OP_W    = 4,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  multicycle_control_if.master mem,
  output logic                ir_write,
  output logic                pc_write,
  output logic                branch_en,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                use_immediate,
  output logic                reg_write,
  output logic [CNT_W-1:0]    instret,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [2:0]          state
);

  // ALU operation encodings shared with the datapath ALU.
  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  // A zero timeout would trap before memory could ever answer.
  if (MEM_TIMEOUT < 32'sd1) begin : g_timeout_range
    $error("multicycle_control: MEM_TIMEOUT must be >= 1");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             trap_q, trap_d;
  logic [1:0]       trap_cause_q, trap_cause_d;
  logic             timeout_hit_s;
  logic             timeout_s;
  logic             retire_s;
  logic             trap_enter_s;

`ifdef CTRL_MEM_TIMEOUT_EN
  // Counter only needs to reach MEM_TIMEOUT-1; the next wait cycle traps.
  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  logic [WAIT_W-1:0] wait_q, wait_d;

  // Current cycle is the last allowed wait cycle.
  assign timeout_hit_s = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  // Wait counter: cleared on any state change, counts stalled request cycles.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (mem.mem_req && !mem.mem_ready) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = wait_q;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  // No watchdog: memory may stall indefinitely.
  assign timeout_hit_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; timeout_s marks a trap caused by the memory watchdog.
  always_comb begin
    state_d   = state_q;
    timeout_s = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem.mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_hit_s) begin
          state_d   = S_TRAP;
          timeout_s = 1'b1;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opcode)
          OPC_OPIMM, OPC_OP, OPC_BRANCH, OPC_LOAD, OPC_STORE: state_d = S_EXECUTE;
          default:                                             state_d = S_TRAP;
        endcase
      end
      S_EXECUTE: begin
        case (opcode)
          OPC_OPIMM, OPC_OP:   state_d = S_WB;
          OPC_BRANCH:          state_d = S_FETCH;
          OPC_LOAD, OPC_STORE: state_d = S_MEM;
          // Opcode must not change after DECODE; treat it as illegal if it does.
          default:             state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        if (mem.mem_ready) begin
          if (opcode == OPC_STORE) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_hit_s) begin
          state_d   = S_TRAP;
          timeout_s = 1'b1;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Output decode from current state (plus opcode/funct and mem_ready).
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    branch_en     = 1'b0;
    alu_op        = ALU_ADD;
    use_immediate = 1'b0;
    reg_write     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end else begin
          ir_write = 1'b0;
          pc_write = 1'b0;
        end
      end
      S_EXECUTE: begin
        case (opcode)
          OPC_OPIMM: begin
            alu_op        = ALU_ADD;
            use_immediate = 1'b1;
          end
          OPC_OP: begin
            if ((funct3 == 3'b000) && (funct7 == 7'b0100000)) begin
              alu_op = ALU_SUB;
            end else begin
              alu_op = ALU_ADD;
            end
          end
          OPC_BRANCH: begin
            alu_op    = ALU_SUB;
            branch_en = 1'b1;
          end
          OPC_LOAD, OPC_STORE: begin
            alu_op        = ALU_ADD;
            use_immediate = 1'b1;
          end
          default: alu_op = ALU_ADD;
        endcase
      end
      S_MEM: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = (opcode == OPC_STORE);
      end
      S_WB:    reg_write = 1'b1;
      default: reg_write = 1'b0;
    endcase
  end

  assign retire_s     = (state_d == S_FETCH) &&
                        ((state_q == S_EXECUTE) || (state_q == S_MEM) || (state_q == S_WB));
  assign trap_enter_s = (state_d == S_TRAP) && (state_q != S_TRAP);

  // Next values for the retire counter and the sticky trap status.
  always_comb begin
    instret_d    = instret_q;
    trap_d       = trap_q;
    trap_cause_d = trap_cause_q;
    if (retire_s) begin
      instret_d = instret_q + CNT_W'(1);
    end else begin
      instret_d = instret_q;
    end
    if (trap_enter_s) begin
      trap_d       = 1'b1;
      trap_cause_d = timeout_s ? CAUSE_TIMEOUT : CAUSE_ILLEGAL;
    end else begin
      trap_d       = trap_q;
      trap_cause_d = trap_cause_q;
    end
  end

  // Retire counter and trap status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q    <= '0;
      trap_q       <= 1'b0;
      trap_cause_q <= CAUSE_NONE;
    end else begin
      instret_q    <= instret_d;
      trap_q       <= trap_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  assign instret    = instret_q;
  assign trap       = trap_q;
  assign trap_cause = trap_cause_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each scenario pushes per-cycle
// stimulus and expected outputs, the driver replays stimulus and records what
// the DUT shows, and the scenario task compares the two queues.
module tb_multicycle_control;
`ifdef CTRL_MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  localparam logic [3:0] A_ADD = 4'd0;
  localparam logic [3:0] A_SUB = 4'd1;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = 7'b1111111;
  logic [2:0]  funct3 = 3'b000;
  logic [6:0]  funct7 = 7'b0000000;
  logic        ir_write, pc_write, branch_en, use_immediate, reg_write, trap;
  logic [3:0]  alu_op;
  logic [31:0] instret;
  logic [1:0]  trap_cause;
  logic [2:0]  dut_state;

  multicycle_control_if mif ();

  multicycle_control #(.ALU_OP_W(4), .CNT_W(32), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .mem(mif.master), .ir_write(ir_write), .pc_write(pc_write), .branch_en(branch_en),
    .alu_op(alu_op), .use_immediate(use_immediate), .reg_write(reg_write),
    .instret(instret), .trap(trap), .trap_cause(trap_cause), .state(dut_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        req, we, irw, pcw, br;
    logic [3:0]  alu;
    logic        imm, rw, trp;
    logic [1:0]  cause;
    logic [31:0] ret;
  } obs_t;

  typedef struct packed {
    logic       rdy;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
  } stim_t;

  obs_t  exp_q[$];
  obs_t  obs_q[$];
  stim_t stim_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  logic [31:0] model_ret = 32'd0;

  function automatic obs_t idle_obs(input logic [2:0] st);
    obs_t o;
    o = '0;
    o.st  = st;
    o.alu = A_ADD;
    o.ret = model_ret;
    return o;
  endfunction

  function automatic stim_t mk_stim(input logic rdy, input logic [6:0] opc,
                                    input logic [2:0] f3, input logic [6:0] f7);
    stim_t s;
    s.rdy = rdy; s.opc = opc; s.f3 = f3; s.f7 = f7;
    return s;
  endfunction

  // FETCH phase: opcode is garbage there and must be ignored.
  task automatic push_fetch(input int fwait);
    obs_t o;
    for (int i = 0; i < fwait; i++) begin
      o = idle_obs(3'd0); o.req = 1'b1;
      stim_q.push_back(mk_stim(1'b0, 7'b1111111, 3'b111, 7'b0100000)); exp_q.push_back(o);
    end
    o = idle_obs(3'd0); o.req = 1'b1; o.irw = 1'b1; o.pcw = 1'b1;
    stim_q.push_back(mk_stim(1'b1, 7'b1111111, 3'b111, 7'b0100000)); exp_q.push_back(o);
  endtask

  // Expected cycle-by-cycle behaviour of one legal instruction.
  task automatic push_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                            input int fwait, input int mwait);
    obs_t o;
    push_fetch(fwait);
    stim_q.push_back(mk_stim(1'b0, opc, f3, f7)); exp_q.push_back(idle_obs(3'd1));
    o = idle_obs(3'd2);
    if (opc == OPIMM || opc == LOAD || opc == STORE) o.imm = 1'b1;
    if (opc == OP && f3 == 3'b000 && f7 == 7'b0100000) o.alu = A_SUB;
    if (opc == BRANCH) begin o.alu = A_SUB; o.br = 1'b1; end
    stim_q.push_back(mk_stim(1'b0, opc, f3, f7)); exp_q.push_back(o);
    if (opc == LOAD || opc == STORE) begin
      o = idle_obs(3'd3); o.req = 1'b1; o.we = (opc == STORE);
      for (int i = 0; i <= mwait; i++) begin
        stim_q.push_back(mk_stim(i == mwait, opc, f3, f7)); exp_q.push_back(o);
      end
    end
    if (opc == OPIMM || opc == OP || opc == LOAD) begin
      o = idle_obs(3'd4); o.rw = 1'b1;
      stim_q.push_back(mk_stim(1'b0, opc, f3, f7)); exp_q.push_back(o);
    end
    model_ret = model_ret + 32'd1;
  endtask

  task automatic push_trap(input int n, input logic [1:0] cause);
    obs_t o;
    for (int i = 0; i < n; i++) begin
      o = idle_obs(3'd5); o.trp = 1'b1; o.cause = cause;
      stim_q.push_back(mk_stim(1'($urandom_range(0, 1)), 7'($urandom), 3'($urandom), 7'($urandom)));
      exp_q.push_back(o);
    end
  endtask

  // Replays queued stimulus one clock per entry; starts and ends at posedge+1.
  task automatic run_cycles();
    stim_t s;
    obs_t  a;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      mif.mem_ready = s.rdy; opcode = s.opc; funct3 = s.f3; funct7 = s.f7;
      @(negedge clk);
      a.st = dut_state; a.req = mif.mem_req; a.we = mif.mem_we; a.irw = ir_write;
      a.pcw = pc_write; a.br = branch_en; a.alu = alu_op; a.imm = use_immediate;
      a.rw = reg_write; a.trp = trap; a.cause = trap_cause; a.ret = instret;
      obs_q.push_back(a);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; mif.mem_ready = 1'b0; opcode = 7'b1111111;
    #23;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_ret = 32'd0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (dut_state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d expected 0", dut_state); end
    n_checks++; if (instret !== 32'd0) begin n_fail++; $display("FAIL reset_instret got %0d expected 0", instret); end
    n_checks++; if (trap !== 1'b0) begin n_fail++; $display("FAIL reset_trap got %b expected 0", trap); end
    n_checks++; if (trap_cause !== 2'b00) begin n_fail++; $display("FAIL reset_cause got %b expected 00", trap_cause); end
    n_checks++; if (mif.mem_req !== 1'b1 || ir_write !== 1'b0) begin
      n_fail++; $display("FAIL reset_fetch req=%b irw=%b expected req=1 irw=0", mif.mem_req, ir_write);
    end
  endtask

  task automatic test_op_imm();
    obs_t e, a;
    push_instr(OPIMM, 3'b000, 7'b0000000, 0, 0);
    run_cycles();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = obs_q.pop_front(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL op_imm st=%0d got %h expected %h", e.st, a, e); end
    end
    n_checks++; if (instret !== 32'd1) begin n_fail++; $display("FAIL op_imm_instret got %0d expected 1", instret); end
  endtask

  task automatic test_op();
    obs_t e, a;
    push_instr(OP, 3'b000, 7'b0100000, 0, 0);
    push_instr(OP, 3'b000, 7'b0000000, 1, 0);
    push_instr(OP, 3'b111, 7'b0100000, 0, 0);
    run_cycles();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = obs_q.pop_front(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL op st=%0d got %h expected %h", e.st, a, e); end
    end
    n_checks++; if (instret !== model_ret) begin n_fail++; $display("FAIL op_instret got %0d expected %0d", instret, model_ret); end
  endtask

  task automatic test_load_store();
    obs_t e, a;
    push_instr(LOAD, 3'b010, 7'b0000000, 2, 3);
    push_instr(STORE, 3'b010, 7'b0000000, 0, 0);
    push_instr(STORE, 3'b010, 7'b0000000, 0, 2);
    run_cycles();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = obs_q.pop_front(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL load_store st=%0d got %h expected %h", e.st, a, e); end
    end
    n_checks++; if (instret !== model_ret) begin n_fail++; $display("FAIL ls_instret got %0d expected %0d", instret, model_ret); end
  endtask

  task automatic test_branch();
    obs_t e, a;
    push_instr(BRANCH, 3'b000, 7'b0000000, 0, 0);
    push_instr(BRANCH, 3'b001, 7'b0000000, 1, 0);
    run_cycles();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = obs_q.pop_front(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL branch st=%0d got %h expected %h", e.st, a, e); end
    end
    n_checks++; if (instret !== model_ret) begin n_fail++; $display("FAIL branch_instret got %0d expected %0d", instret, model_ret); end
  endtask

  task automatic test_back_to_back();
    obs_t e, a;
    logic [6:0] opcs [5];
    logic [6:0] opc;
    opcs[0] = OPIMM; opcs[1] = OP; opcs[2] = BRANCH; opcs[3] = LOAD; opcs[4] = STORE;
    for (int i = 0; i < 24; i++) begin
      opc = opcs[$urandom_range(0, 4)];
      push_instr(opc, ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom),
                 ($urandom_range(0, 1) == 0) ? 7'b0100000 : 7'b0000000,
                 $urandom_range(0, 3), $urandom_range(0, 3));
    end
    run_cycles();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = obs_q.pop_front(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL back_to_back st=%0d got %h expected %h", e.st, a, e); end
    end
    n_checks++; if (instret !== model_ret) begin n_fail++; $display("FAIL b2b_instret got %0d expected %0d", instret, model_ret); end
  endtask

  task automatic test_mem_wait();
    obs_t e, a, o;
`ifdef CTRL_MEM_TIMEOUT_EN
    // Ready on the last allowed wait cycle wins over the watchdog.
    push_instr(LOAD, 3'b010, 7'b0000000, TO - 1, TO - 1);
    // Fetch stuck: TO request cycles, then trap with cause 10.
    for (int i = 0; i < TO; i++) begin
      o = idle_obs(3'd0); o.req = 1'b1;
      stim_q.push_back(mk_stim(1'b0, 7'b1111111, 3'b000, 7'b0000000)); exp_q.push_back(o);
    end
    push_trap(6, 2'b10);
`else
    // Without the watchdog long stalls are simply waited out.
    push_instr(LOAD, 3'b010, 7'b0000000, 25, 25);
    push_instr(STORE, 3'b010, 7'b0000000, 30, 20);
`endif
    run_cycles();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = obs_q.pop_front(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL mem_wait st=%0d got %h expected %h", e.st, a, e); end
    end
`ifdef CTRL_MEM_TIMEOUT_EN
    do_reset();
    // Watchdog in MEM: load with memory never answering.
    push_fetch(0);
    stim_q.push_back(mk_stim(1'b0, LOAD, 3'b010, 7'b0000000)); exp_q.push_back(idle_obs(3'd1));
    o = idle_obs(3'd2); o.imm = 1'b1;
    stim_q.push_back(mk_stim(1'b0, LOAD, 3'b010, 7'b0000000)); exp_q.push_back(o);
    for (int i = 0; i < TO; i++) begin
      o = idle_obs(3'd3); o.req = 1'b1;
      stim_q.push_back(mk_stim(1'b0, LOAD, 3'b010, 7'b0000000)); exp_q.push_back(o);
    end
    push_trap(3, 2'b10);
    run_cycles();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = obs_q.pop_front(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL mem_timeout st=%0d got %h expected %h", e.st, a, e); end
    end
`endif
  endtask

  task automatic test_illegal();
    obs_t e, a;
    push_instr(OPIMM, 3'b000, 7'b0000000, 0, 0);
    push_fetch(1);
    stim_q.push_back(mk_stim(1'b0, 7'b1111111, 3'b000, 7'b0000000)); exp_q.push_back(idle_obs(3'd1));
    push_trap(20, 2'b01);
    run_cycles();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = obs_q.pop_front(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL illegal st=%0d got %h expected %h", e.st, a, e); end
    end
    // Asynchronous reset away from any clock edge clears everything at once.
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (dut_state !== 3'd0 || trap !== 1'b0 || trap_cause !== 2'b00 || instret !== 32'd0) begin
      n_fail++; $display("FAIL async_reset got st=%0d trap=%b cause=%b ret=%0d expected 0/0/00/0",
                         dut_state, trap, trap_cause, instret);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_ret = 32'd0;
    push_instr(STORE, 3'b010, 7'b0000000, 0, 0);
    run_cycles();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = obs_q.pop_front(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL post_reset st=%0d got %h expected %h", e.st, a, e); end
    end
    n_checks++; if (instret !== 32'd1) begin n_fail++; $display("FAIL post_reset_instret got %0d expected 1", instret); end
  endtask

  initial begin
    mif.mem_ready = 1'b0;
    test_reset();
    test_op_imm();
    test_op();
    test_load_store();
    test_branch();
    test_back_to_back();
    test_mem_wait();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
